// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the seven-segment scanner: FSM encoding and active-low {g,f,e,d,c,b,a} patterns.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to active-low segment decode; non-decimal codes show a dash.
module bcd_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_DIGITS[0];
      4'd1: seg_o = SEG_DIGITS[1];
      4'd2: seg_o = SEG_DIGITS[2];
      4'd3: seg_o = SEG_DIGITS[3];
      4'd4: seg_o = SEG_DIGITS[4];
      4'd5: seg_o = SEG_DIGITS[5];
      4'd6: seg_o = SEG_DIGITS[6];
      4'd7: seg_o = SEG_DIGITS[7];
      4'd8: seg_o = SEG_DIGITS[8];
      4'd9: seg_o = SEG_DIGITS[9];
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display driver: advances one digit per slow_clk_in edge with dark gaps between digits.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        slow_clk_in,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

  logic sync1_q, sync2_q, edge_q;
  logic tick;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= slow_clk_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~edge_q;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [15:0] snap_val_q;
  logic [3:0]  snap_dp_q;
  logic [3:0]  anode_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic        frame_start_q;

  logic        enter_drive;
  logic [1:0]  drv_idx;
  logic        load_snap;
  logic [15:0] src_val;
  logic [3:0]  src_dp;
  logic [3:0]  digit;
  logic [6:0]  digit_seg;
  logic        lz_hide;

  // BLANK already holds the advanced index; a zero-length blank advances on the way into DRIVE.
  always_comb begin
    drv_idx     = (state_q == ST_BLANK) ? idx_q : idx_q + 2'd1;
    enter_drive = 1'b0;
    if (enable) begin
      if (state_q == ST_BLANK) begin
        enter_drive = (cnt_q == BLANK_LAST);
      end else if (BLANK_CYCLES == 0) begin
        enter_drive = tick;
      end
    end
  end

  // Digit 0 decodes straight from the inputs being captured so the whole frame uses one snapshot.
  assign load_snap = enter_drive && (drv_idx == 2'd0);
  assign src_val   = load_snap ? value : snap_val_q;
  assign src_dp    = load_snap ? dp_en : snap_dp_q;
  assign digit     = src_val[{drv_idx, 2'b00} +: 4];
  assign lz_hide   = LZ_BLANK && (drv_idx != 2'd0) && ((src_val >> {drv_idx, 2'b00}) == 16'd0);

  bcd_to_seg u_dec (
    .bcd_i (digit),
    .seg_o (digit_seg)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd3;
      cnt_q         <= 8'd0;
      snap_val_q    <= 16'd0;
      snap_dp_q     <= 4'd0;
      anode_q       <= 4'hF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (!enable) begin
        state_q <= ST_IDLE;
        anode_q <= 4'hF;
        seg_q   <= SEG_BLANK;
        dp_q    <= 1'b1;
      end else if (enter_drive) begin
        state_q       <= ST_DRIVE;
        idx_q         <= drv_idx;
        anode_q       <= ~(4'b0001 << drv_idx);
        seg_q         <= lz_hide ? SEG_BLANK : digit_seg;
        dp_q          <= ~src_dp[drv_idx];
        frame_start_q <= (drv_idx == 2'd0);
        if (load_snap) begin
          snap_val_q <= value;
          snap_dp_q  <= dp_en;
        end
      end else begin
        case (state_q)
          ST_BLANK: cnt_q <= cnt_q + 8'd1;
          ST_IDLE, ST_DRIVE: begin
            if (tick) begin
              state_q <= ST_BLANK;
              idx_q   <= idx_q + 2'd1;
              cnt_q   <= 8'd0;
              anode_q <= 4'hF;
              seg_q   <= SEG_BLANK;
              dp_q    <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
